ifm_window_buf: RTL and testbench

- Parametrised KxK input-feature-map window buffer feeding the PE array.
- Generalises the fixed 3x3 shift buffer: configurable kernel size, data width and tile size.
- Serpentine (right / down / left / down ...) scan over an output tile, driven by a start/done command.
- Valid/ready handshakes on both the input beat stream and the window output, plus a direct-load pooling mode.

---
 rtl/cnn_pkg.sv | 40 ++++
 rtl/ifm_window_buf_shift_reg.sv | 92 +++++++++
 rtl/ifm_window_buf.sv | 218 +++++++++++++++++++++
 tb/tb_ifm_window_buf.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types for the input-feature-map window buffer.
//   layer_t  : layer kind carried on the layer_type command port
//   move_t   : direction of the serpentine scan step between conv windows
//   state_t  : control FSM states of ifm_window_buf
//   wsr_op_t : per-cycle operation applied to the KxK window register array
package cnn_pkg;

   typedef enum logic [1:0] {
      LT_NONE  = 2'b00,
      LT_CONV  = 2'b01,
      LT_POOL  = 2'b10,
      LT_FULLY = 2'b11
   } layer_t;

   typedef enum logic [1:0] {
      MV_RIGHT = 2'd0,
      MV_DOWN  = 2'd1,
      MV_LEFT  = 2'd2,
      MV_HOLD  = 2'd3
   } move_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_FILL = 3'd1,
      ST_EMIT = 3'd2,
      ST_MOVE = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      OP_HOLD        = 3'd0,
      OP_LOAD_COL    = 3'd1,
      OP_LOAD_ROW    = 3'd2,
      OP_LOAD_POOL   = 3'd3,
      OP_SHIFT_LEFT  = 3'd4,
      OP_SHIFT_RIGHT = 3'd5,
      OP_SHIFT_UP    = 3'd6
   } wsr_op_t;

endpackage

// File: rtl/ifm_window_buf_shift_reg.sv
// window_shift_reg: KxK register array holding one input window.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears all elements)
//   op         : operation for this cycle (hold / load column / load row /
//                pooling pack / shift left / shift right / shift up)
//   idx        : column, row or pooling beat index for the load operations
//   beat       : K lanes, lane i = beat[i*DATA_W +: DATA_W]
//   win        : K*K elements, element r*K+c row-major
module window_shift_reg
   import cnn_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int K      = 3,
   parameter int POOL_K = 2,
   parameter int IDX_W  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  wsr_op_t               op,
   input  logic [IDX_W-1:0]      idx,
   input  logic [K*DATA_W-1:0]   beat,
   output logic [K*K*DATA_W-1:0] win
);

   localparam int PP = POOL_K * POOL_K;

   logic [DATA_W-1:0] lane [K];

   genvar gi;
   generate
      for (gi = 0; gi < K; gi++) begin : g_lane
         assign lane[gi] = beat[gi*DATA_W +: DATA_W];
      end

      for (gi = 0; gi < K*K; gi++) begin : g_elem
         localparam int R = gi / K;
         localparam int C = gi % K;

         logic [DATA_W-1:0] e_q, e_d;
         logic [DATA_W-1:0] left_src, right_src, up_src, pool_val;

         // Neighbours are read back from the flattened output so each element
         // owns exactly one register.
         if (C < K-1) begin : g_l
            assign left_src = win[(gi+1)*DATA_W +: DATA_W];
         end else begin : g_l_edge
            assign left_src = lane[R];
         end
         if (C > 0) begin : g_r
            assign right_src = win[(gi-1)*DATA_W +: DATA_W];
         end else begin : g_r_edge
            assign right_src = lane[R];
         end
         if (R < K-1) begin : g_u
            assign up_src = win[(gi+K)*DATA_W +: DATA_W];
         end else begin : g_u_edge
            assign up_src = lane[C];
         end

         // Pooling pack: element gi comes from beat gi/K, lane gi%K. The first
         // beat clears everything it does not write so stale conv data never
         // leaks into a pooling window; padding elements stay zero.
         if (gi >= PP) begin : g_pad
            assign pool_val = '0;
         end else begin : g_pool
            assign pool_val = (idx == IDX_W'(R)) ? lane[C] :
                              (idx == '0)        ? '0      : e_q;
         end

         always_comb begin
            e_d = e_q;
            case (op)
               OP_LOAD_COL:    if (idx == IDX_W'(C)) e_d = lane[R];
               OP_LOAD_ROW:    if (idx == IDX_W'(R)) e_d = lane[C];
               OP_LOAD_POOL:   e_d = pool_val;
               OP_SHIFT_LEFT:  e_d = left_src;
               OP_SHIFT_RIGHT: e_d = right_src;
               OP_SHIFT_UP:    e_d = up_src;
               default:        e_d = e_q;
            endcase
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) e_q <= '0;
            else        e_q <= e_d;
         end

         assign win[gi*DATA_W +: DATA_W] = e_q;
      end
   endgenerate

endmodule

// File: rtl/ifm_window_buf.sv
// ifm_window_buf: KxK input-feature-map window buffer feeding the PE array.
// A start command launches a job; conv jobs scan the output tile in serpentine
// order reusing K*(K-1) elements per step, pool/fully jobs reload every window.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, layer_type,
//   out_rows, out_cols   : job command, sampled only when accepted in IDLE
//   in_data/valid/ready  : K-lane input beat stream
//   win_data/valid/ready : K*K window output stream, row-major
//   busy                 : high whenever the FSM is not in IDLE
//   done                 : one-cycle pulse after the last window is consumed
module ifm_window_buf
   import cnn_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int K      = 3,
   parameter int POOL_K = 2,
   parameter int DIM_W  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            layer_type,
   input  logic [DIM_W-1:0]      out_rows,
   input  logic [DIM_W-1:0]      out_cols,
   input  logic [K*DATA_W-1:0]   in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [K*K*DATA_W-1:0] win_data,
   output logic                  win_valid,
   input  logic                  win_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int PP    = POOL_K * POOL_K;
   localparam int PB    = (PP + K - 1) / K;
   localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
   localparam int CNT_W = 2 * DIM_W;

   state_t             state_q, state_d;
   layer_t             layer_q, layer_d;
   move_t              move_q, move_d;
   logic [IDX_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [DIM_W-1:0]   cols_q, cols_d;
   logic [DIM_W-1:0]   col_q, col_d;
   logic               dir_q, dir_d;       // 0: scanning right, 1: scanning left
   logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0]   total_q, total_d;
   logic               in_ready_q, in_ready_d;
   logic               win_valid_q, win_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   wsr_op_t            op;
   logic [IDX_W-1:0]   op_idx;
   layer_t             start_lt;
   logic               in_fire, win_fire, last_win;
   logic [IDX_W-1:0]   fill_last;

   assign start_lt  = layer_t'(layer_type);
   assign in_fire   = in_valid && in_ready_q;
   assign win_fire  = win_valid_q && win_ready;
   assign last_win  = (win_cnt_q == total_q - CNT_W'(1));
   assign fill_last = (layer_q == LT_POOL) ? IDX_W'(PB - 1) : IDX_W'(K - 1);

   always_comb begin
      state_d    = state_q;
      layer_d    = layer_q;
      move_d     = move_q;
      beat_cnt_d = beat_cnt_q;
      cols_d     = cols_q;
      col_d      = col_q;
      dir_d      = dir_q;
      win_cnt_d  = win_cnt_q;
      total_d    = total_q;
      op         = OP_HOLD;
      op_idx     = beat_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               layer_d    = start_lt;
               cols_d     = out_cols;
               col_d      = '0;
               dir_d      = 1'b0;
               beat_cnt_d = '0;
               win_cnt_d  = '0;
               move_d     = MV_HOLD;
               // pool/fully produce one window per output column only
               total_d    = (start_lt == LT_CONV) ? CNT_W'(out_rows) * CNT_W'(out_cols)
                                                  : CNT_W'(out_cols);
               if (start_lt == LT_NONE || out_rows == '0 || out_cols == '0)
                  state_d = ST_FIN;
               else
                  state_d = ST_FILL;
            end
         end

         ST_FILL: begin
            if (in_fire) begin
               case (layer_q)
                  LT_POOL:  op = OP_LOAD_POOL;
                  LT_FULLY: op = OP_LOAD_ROW;
                  default:  op = OP_LOAD_COL;
               endcase
               if (beat_cnt_q == fill_last) begin
                  beat_cnt_d = '0;
                  state_d    = ST_EMIT;
               end else begin
                  beat_cnt_d = beat_cnt_q + IDX_W'(1);
               end
            end
         end

         ST_EMIT: begin
            if (win_fire) begin
               win_cnt_d = win_cnt_q + CNT_W'(1);
               if (last_win) begin
                  state_d = ST_FIN;
               end else if (layer_q == LT_CONV) begin
                  state_d = ST_MOVE;
                  // Serpentine: step along the row until its end, then step down.
                  if (!dir_q && col_q != cols_q - DIM_W'(1))
                     move_d = MV_RIGHT;
                  else if (dir_q && col_q != '0)
                     move_d = MV_LEFT;
                  else
                     move_d = MV_DOWN;
               end else begin
                  state_d = ST_FILL;
               end
            end
         end

         ST_MOVE: begin
            if (in_fire) begin
               state_d = ST_EMIT;
               case (move_q)
                  MV_RIGHT: begin
                     op    = OP_SHIFT_LEFT;
                     col_d = col_q + DIM_W'(1);
                  end
                  MV_LEFT: begin
                     op    = OP_SHIFT_RIGHT;
                     col_d = col_q - DIM_W'(1);
                  end
                  default: begin
                     op    = OP_SHIFT_UP;
                     dir_d = ~dir_q;
                  end
               endcase
            end
         end

         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered as a decode of the next state.
      in_ready_d  = (state_d == ST_FILL) || (state_d == ST_MOVE);
      win_valid_d = (state_d == ST_EMIT);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_FIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         layer_q     <= LT_NONE;
         move_q      <= MV_RIGHT;
         beat_cnt_q  <= '0;
         cols_q      <= '0;
         col_q       <= '0;
         dir_q       <= 1'b0;
         win_cnt_q   <= '0;
         total_q     <= '0;
         in_ready_q  <= 1'b0;
         win_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         layer_q     <= layer_d;
         move_q      <= move_d;
         beat_cnt_q  <= beat_cnt_d;
         cols_q      <= cols_d;
         col_q       <= col_d;
         dir_q       <= dir_d;
         win_cnt_q   <= win_cnt_d;
         total_q     <= total_d;
         in_ready_q  <= in_ready_d;
         win_valid_q <= win_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   window_shift_reg #(
      .DATA_W (DATA_W),
      .K      (K),
      .POOL_K (POOL_K),
      .IDX_W  (IDX_W)
   ) u_wsr (
      .clk   (clk),
      .rst_n (rst_n),
      .op    (op),
      .idx   (op_idx),
      .beat  (in_data),
      .win   (win_data)
   );

   assign in_ready  = in_ready_q;
   assign win_valid = win_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_ifm_window_buf.sv
module tb_ifm_window_buf;

   localparam int DATA_W = 8;
   localparam int K      = 3;
   localparam int POOL_K = 2;
   localparam int DIM_W  = 5;
   localparam int WW     = K*K*DATA_W;
   localparam int BW     = K*DATA_W;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [1:0]       layer_type;
   logic [DIM_W-1:0] out_rows;
   logic [DIM_W-1:0] out_cols;
   logic [BW-1:0]    in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WW-1:0]    win_data;
   logic             win_valid;
   logic             win_ready;
   logic             busy;
   logic             done;

   ifm_window_buf #(
      .DATA_W (DATA_W),
      .K      (K),
      .POOL_K (POOL_K),
      .DIM_W  (DIM_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .layer_type (layer_type),
      .out_rows   (out_rows),
      .out_cols   (out_cols),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .win_data   (win_data),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int beats_taken = 0;
   int done_cnt = 0;

   logic [WW-1:0] exp_q[$];
   logic [BW-1:0] beat_q[$];

   // Handshakes are counted mid-cycle where inputs and registered outputs are stable.
   always @(negedge clk) begin
      if (in_valid && in_ready) beats_taken++;
      if (done) done_cnt++;
   end

   function automatic logic [BW-1:0] mk_beat(input int a, input int b, input int c);
      return {8'(c), 8'(b), 8'(a)};
   endfunction

   function automatic logic [WW-1:0] mk_win(input int e0, input int e1, input int e2,
                                            input int e3, input int e4, input int e5,
                                            input int e6, input int e7, input int e8);
      return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [1:0] lt, input int rows, input int cols);
      start      = 1'b1;
      layer_type = lt;
      out_rows   = DIM_W'(rows);
      out_cols   = DIM_W'(cols);
      tick();
      start      = 1'b0;
      // scramble the command inputs: they must be ignored while busy
      layer_type = 2'b00;
      out_rows   = '0;
      out_cols   = '0;
   endtask

   task automatic feed(input int n);
      int   sent = 0;
      int   cyc  = 0;
      logic take;
      in_valid = 1'b1;
      in_data  = beat_q[0];
      while (sent < n && cyc < 300) begin
         take = in_ready;
         tick();
         cyc++;
         if (take) begin
            void'(beat_q.pop_front());
            sent++;
            if (sent < n) in_data = beat_q[0];
         end
      end
      in_valid = 1'b0;
      checks++;
      if (sent != n) begin
         errors++;
         $display("FAIL feed_count: beats accepted=%0d required=%0d", sent, n);
      end
   endtask

   task automatic consume(input int n, input int stall);
      logic [WW-1:0] held;
      logic [WW-1:0] exp;
      int cyc;
      for (int w = 0; w < n; w++) begin
         cyc = 0;
         while (!win_valid && cyc < 300) begin
            tick();
            cyc++;
         end
         checks++;
         if (!win_valid) begin
            errors++;
            $display("FAIL win_timeout: window %0d win_valid=%0b required=1", w, win_valid);
            return;
         end
         held = win_data;
         for (int s = 0; s < stall; s++) begin
            tick();
            checks += 2;
            if (win_data !== held || win_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_hold: window %0d data=%h valid=%0b required data=%h valid=1",
                        w, win_data, win_valid, held);
            end
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL stall_in_ready: window %0d in_ready=%0b required=0", w, in_ready);
            end
         end
         exp = exp_q.pop_front();
         checks++;
         if (win_data !== exp) begin
            errors++;
            $display("FAIL window: idx %0d got=%h exp=%h", w, win_data, exp);
         end else begin
            $display("window %0d ok %h", w, win_data);
         end
         win_ready = 1'b1;
         tick();
         win_ready = 1'b0;
      end
   endtask

   task automatic check_done_end(input string name, input int beats_exp, input int b0, input int d0);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s_done: done=%0b required=1 after last handshake", name, done);
      end
      checks++;
      if (beats_taken - b0 != beats_exp) begin
         errors++;
         $display("FAIL %s_beats: consumed=%0d required=%0d", name, beats_taken - b0, beats_exp);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL %s_idle: done=%0b busy=%0b pulses=%0d required 0 0 1",
                  name, done, busy, done_cnt - d0);
      end
      // beats offered in IDLE must not be consumed
      in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      checks++;
      if (beats_taken - b0 != beats_exp) begin
         errors++;
         $display("FAIL %s_idle_beats: consumed=%0d required=%0d", name, beats_taken - b0, beats_exp);
      end
   endtask

   task automatic run_conv_2x2(input int stall, input bit poke);
      int b0, d0;
      beat_q.push_back(mk_beat(0, 10, 20));
      beat_q.push_back(mk_beat(1, 11, 21));
      beat_q.push_back(mk_beat(2, 12, 22));
      beat_q.push_back(mk_beat(3, 13, 23));
      beat_q.push_back(mk_beat(31, 32, 33));
      beat_q.push_back(mk_beat(10, 20, 30));
      exp_q.push_back(mk_win(0, 1, 2, 10, 11, 12, 20, 21, 22));
      exp_q.push_back(mk_win(1, 2, 3, 11, 12, 13, 21, 22, 23));
      exp_q.push_back(mk_win(11, 12, 13, 21, 22, 23, 31, 32, 33));
      exp_q.push_back(mk_win(10, 11, 12, 20, 21, 22, 30, 31, 32));
      b0 = beats_taken;
      d0 = done_cnt;
      start_job(2'b01, 2, 2);
      fork
         feed(6);
         consume(4, stall);
         begin
            if (poke) begin
               // a second command while busy must be ignored
               start      = 1'b1;
               layer_type = 2'b00;
               tick();
               start      = 1'b0;
            end
         end
      join
      check_done_end("conv2x2", 6, b0, d0);
   endtask

   task automatic test_reset();
      checks++;
      if (win_data !== '0 || busy !== 1'b0 || in_ready !== 1'b0 ||
          win_valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: win=%h busy=%0b in_ready=%0b win_valid=%0b done=%0b required all 0",
                  win_data, busy, in_ready, win_valid, done);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: busy=%0b in_ready=%0b done=%0b required 0", busy, in_ready, done);
      end
      $display("reset ok");
   endtask

   task automatic test_conv();
      run_conv_2x2(0, 1'b0);
   endtask

   task automatic test_stall();
      run_conv_2x2(5, 1'b0);
   endtask

   task automatic test_busy_start();
      run_conv_2x2(0, 1'b1);
   endtask

   task automatic test_pool();
      int b0, d0;
      beat_q.push_back(mk_beat(1, 2, 3));
      beat_q.push_back(mk_beat(4, 99, 98));
      beat_q.push_back(mk_beat(5, 6, 7));
      beat_q.push_back(mk_beat(8, 97, 96));
      exp_q.push_back(mk_win(1, 2, 3, 4, 0, 0, 0, 0, 0));
      exp_q.push_back(mk_win(5, 6, 7, 8, 0, 0, 0, 0, 0));
      b0 = beats_taken;
      d0 = done_cnt;
      start_job(2'b10, 7, 2);
      fork
         feed(4);
         consume(2, 0);
      join
      check_done_end("pool", 4, b0, d0);
   endtask

   task automatic test_down_only();
      int b0, d0;
      beat_q.push_back(mk_beat(0, 10, 20));
      beat_q.push_back(mk_beat(1, 11, 21));
      beat_q.push_back(mk_beat(2, 12, 22));
      beat_q.push_back(mk_beat(30, 31, 32));
      beat_q.push_back(mk_beat(40, 41, 42));
      exp_q.push_back(mk_win(0, 1, 2, 10, 11, 12, 20, 21, 22));
      exp_q.push_back(mk_win(10, 11, 12, 20, 21, 22, 30, 31, 32));
      exp_q.push_back(mk_win(20, 21, 22, 30, 31, 32, 40, 41, 42));
      b0 = beats_taken;
      d0 = done_cnt;
      start_job(2'b01, 3, 1);
      fork
         feed(5);
         consume(3, 1);
      join
      check_done_end("down_only", 5, b0, d0);
   endtask

   task automatic test_empty_jobs();
      int b0;
      logic [1:0] lt_tab [2];
      int         rows_tab [2];
      lt_tab[0] = 2'b00; rows_tab[0] = 2;
      lt_tab[1] = 2'b01; rows_tab[1] = 0;
      for (int t = 0; t < 2; t++) begin
         b0       = beats_taken;
         in_valid = 1'b1;
         in_data  = mk_beat(7, 7, 7);
         start_job(lt_tab[t], rows_tab[t], 2);
         checks++;
         if (done !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: job %0d done=%0b in_ready=%0b required 1 0", t, done, in_ready);
         end
         tick();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || beats_taken != b0) begin
            errors++;
            $display("FAIL empty_after: job %0d done=%0b busy=%0b beats=%0d required 0 0 0",
                     t, done, busy, beats_taken - b0);
         end
         in_valid = 1'b0;
         $display("empty job %0d checked", t);
      end
   endtask

   task automatic test_reset_mid();
      int d0;
      beat_q.push_back(mk_beat(0, 10, 20));
      beat_q.push_back(mk_beat(1, 11, 21));
      beat_q.push_back(mk_beat(2, 12, 22));
      exp_q.push_back(mk_win(0, 1, 2, 10, 11, 12, 20, 21, 22));
      start_job(2'b01, 2, 2);
      feed(3);
      consume(1, 0);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_move: in_ready=%0b busy=%0b required 1 1", in_ready, busy);
      end
      d0 = done_cnt;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (win_data !== '0 || busy !== 1'b0 || in_ready !== 1'b0 || win_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: win=%h busy=%0b in_ready=%0b win_valid=%0b required all 0",
                  win_data, busy, in_ready, win_valid);
      end
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      checks++;
      if (done_cnt != d0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_no_done: pulses=%0d busy=%0b required 0 0", done_cnt - d0, busy);
      end
      $display("mid reset checked");
      run_conv_2x2(0, 1'b0);
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      layer_type = 2'b00;
      out_rows   = '0;
      out_cols   = '0;
      in_data    = '0;
      in_valid   = 1'b0;
      win_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_conv();
      test_stall();
      test_busy_start();
      test_pool();
      test_down_only();
      test_empty_jobs();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
